// File: rtl/pwm_duty_monitor.sv
// pwm_duty_monitor: measures the high-time of each 2^FRAME_BITS-cycle frame of
// a PWM line, keeps a moving average over 2^AVG_LOG2 frames and flags lines
// that stay saturated high or low for STUCK_FRAMES consecutive frames.
module pwm_duty_monitor #(
  parameter int FRAME_BITS   = 6,
  parameter int AVG_LOG2     = 2,
  parameter int STUCK_FRAMES = 8
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  Enable,
  input  logic                  Pulse_In,
  output logic [FRAME_BITS:0]   Duty_Meas,
  output logic [FRAME_BITS:0]   Duty_Avg,
  output logic                  Meas_Valid,
  output logic                  Stuck_High,
  output logic                  Stuck_Low
);

  localparam int DW    = FRAME_BITS + 1;
  localparam int SW    = DW + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;

  localparam logic [FRAME_BITS-1:0] LAST_CNT  = {FRAME_BITS{1'b1}};
  localparam logic [DW-1:0]         FULL_VAL  = DW'(1 << FRAME_BITS);
  localparam logic [DW-1:0]         EMPTY_VAL = DW'(0);
  localparam logic [7:0]            STUCK_MAX = 8'(STUCK_FRAMES);

  logic [FRAME_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]         hi_cnt_q, hi_cnt_d;
  logic [DW-1:0]         hist_q [DEPTH];
  logic [DW-1:0]         hist_d [DEPTH];
  logic [SW-1:0]         sum_q, sum_d;
  logic [7:0]            hi_run_q, hi_run_d;
  logic [7:0]            lo_run_q, lo_run_d;
  logic [DW-1:0]         meas_q, meas_d;
  logic [DW-1:0]         avg_q, avg_d;
  logic                  valid_q, valid_d;
  logic                  stuck_hi_q, stuck_hi_d;
  logic                  stuck_lo_q, stuck_lo_d;

  logic                  frame_end_s;
  logic [DW-1:0]         new_meas_s;

  // Frame end happens on the enabled sample taken while the counter reads its last value;
  // the current sample is folded into the count so all samples of the frame contribute.
  always_comb begin
    frame_end_s = Enable && (frame_cnt_q == LAST_CNT);
    new_meas_s  = hi_cnt_q + DW'(Pulse_In);
  end

  // Next-state for frame counting, history, average and stuck detection.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    hist_d      = hist_q;
    sum_d       = sum_q;
    hi_run_d    = hi_run_q;
    lo_run_d    = lo_run_q;
    meas_d      = meas_q;
    avg_d       = avg_q;
    valid_d     = 1'b0;
    stuck_hi_d  = stuck_hi_q;
    stuck_lo_d  = stuck_lo_q;

    if (!Enable) begin
      // A partial frame is discarded; measured results hold.
      frame_cnt_d = '0;
      hi_cnt_d    = '0;
    end else if (frame_end_s) begin
      frame_cnt_d = '0;
      hi_cnt_d    = '0;
      meas_d      = new_meas_s;
      sum_d       = sum_q + SW'(new_meas_s) - SW'(hist_q[DEPTH-1]);
      avg_d       = DW'(sum_d >> AVG_LOG2);
      valid_d     = 1'b1;
      hist_d[0]   = new_meas_s;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end

      if (new_meas_s == FULL_VAL) begin
        hi_run_d = (hi_run_q == STUCK_MAX) ? hi_run_q : hi_run_q + 8'd1;
      end else begin
        hi_run_d = 8'd0;
      end

      if (new_meas_s == EMPTY_VAL) begin
        lo_run_d = (lo_run_q == STUCK_MAX) ? lo_run_q : lo_run_q + 8'd1;
      end else begin
        lo_run_d = 8'd0;
      end

      stuck_hi_d = (hi_run_d == STUCK_MAX);
      stuck_lo_d = (lo_run_d == STUCK_MAX);
    end else begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      hi_cnt_d    = hi_cnt_q + DW'(Pulse_In);
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      hi_cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      sum_q       <= '0;
      hi_run_q    <= 8'd0;
      lo_run_q    <= 8'd0;
      meas_q      <= '0;
      avg_q       <= '0;
      valid_q     <= 1'b0;
      stuck_hi_q  <= 1'b0;
      stuck_lo_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
      sum_q       <= sum_d;
      hi_run_q    <= hi_run_d;
      lo_run_q    <= lo_run_d;
      meas_q      <= meas_d;
      avg_q       <= avg_d;
      valid_q     <= valid_d;
      stuck_hi_q  <= stuck_hi_d;
      stuck_lo_q  <= stuck_lo_d;
    end
  end

  assign Duty_Meas  = meas_q;
  assign Duty_Avg   = avg_q;
  assign Meas_Valid = valid_q;
  assign Stuck_High = stuck_hi_q;
  assign Stuck_Low  = stuck_lo_q;

endmodule

// File: tb/tb_pwm_duty_monitor.sv
// Bench for pwm_duty_monitor: a frame-level model (list of completed frame
// measurements) predicts every output each cycle; literal checks pin the model.
module tb_pwm_duty_monitor;

  localparam int FB    = 6;
  localparam int AL    = 2;
  localparam int STUCK = 8;
  localparam int FRAME = 1 << FB;
  localparam int NAVG  = 1 << AL;

  logic        sysclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Enable = 1'b0;
  logic        Pulse_In = 1'b0;
  logic [FB:0] Duty_Meas;
  logic [FB:0] Duty_Avg;
  logic        Meas_Valid;
  logic        Stuck_High;
  logic        Stuck_Low;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // model state
  int m_cnt, m_hi;
  int e_meas, e_avg, e_valid, e_sh, e_sl;
  int hist[$];

  pwm_duty_monitor #(.FRAME_BITS(FB), .AVG_LOG2(AL), .STUCK_FRAMES(STUCK)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .Enable(Enable), .Pulse_In(Pulse_In),
    .Duty_Meas(Duty_Meas), .Duty_Avg(Duty_Avg), .Meas_Valid(Meas_Valid),
    .Stuck_High(Stuck_High), .Stuck_Low(Stuck_Low)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Average of the new value and the previous NAVG-1 frames (zeros before history exists).
  function automatic int avg_with(input int nv);
    int s = nv;
    for (int i = 1; i < NAVG; i++)
      if (hist.size() >= i) s += hist[hist.size() - i];
    return s / NAVG;
  endfunction

  // Length of the trailing run of 'target' including nv, capped at STUCK.
  function automatic int run_with(input int nv, input int target);
    int r;
    if (nv != target) return 0;
    r = 1;
    for (int i = hist.size() - 1; i >= 0 && r < STUCK; i--) begin
      if (hist[i] != target) break;
      r++;
    end
    return r;
  endfunction

  // Frame-level reference model.
  always @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_hi <= 0;
      e_meas <= 0; e_avg <= 0; e_valid <= 0; e_sh <= 0; e_sl <= 0;
      hist.delete();
    end else if (!Enable) begin
      m_cnt <= 0; m_hi <= 0; e_valid <= 0;
    end else if (m_cnt == FRAME - 1) begin
      e_meas  <= m_hi + int'(Pulse_In);
      e_avg   <= avg_with(m_hi + int'(Pulse_In));
      e_sh    <= (run_with(m_hi + int'(Pulse_In), FRAME) >= STUCK) ? 1 : 0;
      e_sl    <= (run_with(m_hi + int'(Pulse_In), 0) >= STUCK) ? 1 : 0;
      e_valid <= 1;
      m_cnt   <= 0;
      m_hi    <= 0;
      hist.push_back(m_hi + int'(Pulse_In));
    end else begin
      m_cnt <= m_cnt + 1;
      m_hi  <= m_hi + int'(Pulse_In);
      e_valid <= 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge sysclk) begin
    if (started) begin
      chk("duty_meas", int'(Duty_Meas), e_meas);
      chk("duty_avg", int'(Duty_Avg), e_avg);
      chk("meas_valid", int'(Meas_Valid), e_valid);
      chk("stuck_high", int'(Stuck_High), e_sh);
      chk("stuck_low", int'(Stuck_Low), e_sl);
    end
  end

  task automatic cyc(input logic en, input logic p);
    Enable = en;
    Pulse_In = p;
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; Enable = 1'b0; Pulse_In = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    chk("reset_meas", int'(Duty_Meas), 0);
    chk("reset_avg", int'(Duty_Avg), 0);
    chk("reset_flags", int'({Meas_Valid, Stuck_High, Stuck_Low}), 0);
    reset_n = 1'b1;
  endtask

  // Run one full enabled frame with the first 'highs' samples high.
  task automatic frame(input int highs);
    for (int i = 0; i < FRAME; i++) begin
      cyc(1'b1, (i < highs) ? 1'b1 : 1'b0);
      if (i < FRAME - 1) chk("no_early_strobe", int'(Meas_Valid), 0);
    end
    chk("strobe", int'(Meas_Valid), 1);
    chk("frame_meas", int'(Duty_Meas), highs);
  endtask

  initial begin
    @(posedge sysclk);
    #1;
    started = 1'b1;

    // constant high: first average 16, then 64, stuck after 8 frames
    do_reset();
    frame(64);
    chk("first_avg", int'(Duty_Avg), 16);
    frame(64); frame(64); frame(64);
    chk("fourth_avg", int'(Duty_Avg), 64);
    for (int f = 5; f <= 8; f++) begin
      frame(64);
      chk("stuck_high_ramp", int'(Stuck_High), (f == 8) ? 1 : 0);
    end
    frame(63);
    chk("stuck_high_clear", int'(Stuck_High), 0);

    // 16 highs per frame
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      frame(16);
      if (f >= 4) chk("avg16", int'(Duty_Avg), 16);
    end

    // enable drop at sample 30: partial frame discarded
    for (int i = 0; i < 30; i++) cyc(1'b1, (i < 16) ? 1'b1 : 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1);
      chk("hold_meas", int'(Duty_Meas), 16);
      chk("no_strobe_disabled", int'(Meas_Valid), 0);
    end
    frame(16);

    // alternating 64/0
    do_reset();
    frame(64); frame(0); frame(64); frame(0);
    chk("alt_avg", int'(Duty_Avg), 32);

    // generator pattern: runs of 32 frames at 64 and 0, reset mid-run
    do_reset();
    for (int f = 0; f < 72; f++) begin
      frame(((f / 32) % 2 == 0) ? 64 : 0);
      if (f == 6 || f == 7) chk("gen_stuck_high", int'(Stuck_High), (f == 7) ? 1 : 0);
      if (f == 38 || f == 39) chk("gen_stuck_low", int'(Stuck_Low), (f == 39) ? 1 : 0);
      if (f == 39) chk("gen_flags_exclusive", int'(Stuck_High), 0);
    end
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrun_reset_meas", int'(Duty_Meas), 0);
    chk("midrun_reset_flags", int'({Meas_Valid, Stuck_High, Stuck_Low}), 0);
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;

    // randomized: per-frame density with occasional enable drops
    begin
      int dens;
      dens = 0;
      for (int i = 0; i < 6000; i++) begin
        if (i % FRAME == 0) begin
          case ($urandom_range(0, 3))
            0: dens = 0;
            1: dens = 64;
            default: dens = $urandom_range(0, 64);
          endcase
        end
        cyc(($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 63) < dens) ? 1'b1 : 1'b0);
      end
    end

    @(negedge sysclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
